// File: rtl/tff_count_sequencer.sv
// tff_count_sequencer
//   A 4-bit counter built from a bank of T flip-flops. A small controller
//   works out the toggle vector for each clock edge. A run starts from IDLE.
//   It loads 0 (counting up) or 15 (counting down). It then toggles toward
//   the terminal count latched at start, pulses done for one cycle, and
//   returns to IDLE. A run can be paused, resumed or aborted along the way.
//
//   Handshake: start and stop are level inputs sampled on every rising clk.
//   The design has no valid/ready pairing. When start and stop are both
//   high, stop wins in every state. In IDLE, having both high does nothing.
//
// Ports
//   clk        in   rising-edge clock for all state
//   rst        in   synchronous active-low reset
//   start      in   begin a run from IDLE / resume from PAUSE
//   stop       in   pause from RUN / abort from PAUSE
//   dir        in   1 = count up, 0 = count down (latched on start from IDLE)
//   limit[3:0] in   terminal count (latched on start from IDLE)
//   count[3:0] out  T flip-flop bank state
//   t_vec[3:0] out  toggle vector applied at the most recent edge
//   busy       out  1 in RUN or PAUSE
//   done       out  one-cycle completion pulse
//   state_dbg  out  current controller state (debug visibility)
module tff_count_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       dir,
  input  logic [3:0] limit,
  output logic [3:0] count,
  output logic [3:0] t_vec,
  output logic       busy,
  output logic       done,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state;
  logic       dir_r;
  logic [3:0] lim_r;
  logic [3:0] t_up;
  logic [3:0] t_dn;
  logic [3:0] t_run;
  logic [3:0] count_n;

  // Ripple-carry style toggle terms. A bit toggles when every lower bit is
  // 1 (counting up) or when every lower bit is 0 (counting down).
  always_comb begin
    count_n = ~count;
    t_up    = {&count[2:0], &count[1:0], count[0], 1'b1};
    t_dn    = {&count_n[2:0], &count_n[1:0], count_n[0], 1'b1};
    t_run   = dir_r ? t_up : t_dn;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      count <= 4'h0;
      t_vec <= 4'h0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dir_r <= 1'b1;
      lim_r <= 4'h0;
    end else begin
      // t_vec and done are single-cycle indications unless set below.
      t_vec <= 4'h0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state <= RUN;
            dir_r <= dir;
            lim_r <= limit;
            count <= dir ? 4'h0 : 4'hF;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state <= PAUSE;
          end else if (count == lim_r) begin
            // busy falls on the same edge that done rises, so the two
            // are never high together.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            count <= count ^ t_run;
            t_vec <= t_run;
          end
        end
        PAUSE: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (start) begin
            state <= RUN;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_tff_count_sequencer.sv
// tb_tff_count_sequencer
//   Table of {inputs, expected outputs} per clock edge, followed by a few
//   randomized up/down runs. Expected outputs are queued when each edge's
//   stimulus is driven, then popped and compared once the edge has happened.
module tb_tff_count_sequencer;

  localparam int W = 10;  // {count, t_vec, busy, done}

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       dir;
  logic [3:0] limit;
  logic [3:0] count;
  logic [3:0] t_vec;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  int n_cmp;
  int n_bad;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic       rst;
    logic       start;
    logic       stop;
    logic       dir;
    logic [3:0] limit;
    logic [3:0] e_count;
    logic [3:0] e_tvec;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t vecs[$];

  tff_count_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .dir       (dir),
    .limit     (limit),
    .count     (count),
    .t_vec     (t_vec),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic s, input logic p,
                              input logic d, input logic [3:0] l,
                              input logic [3:0] c, input logic [3:0] t,
                              input logic b, input logic dn);
    vec_t v;
    v.rst = r; v.start = s; v.stop = p; v.dir = d; v.limit = l;
    v.e_count = c; v.e_tvec = t; v.e_busy = b; v.e_done = dn;
    return v;
  endfunction

  // driver: apply inputs for one edge, queue expectation, compare after edge
  task automatic drive_and_check(input logic r, input logic s, input logic p,
                                 input logic d, input logic [3:0] l,
                                 input logic [W-1:0] e, input string name);
    logic [W-1:0] got;
    logic [W-1:0] want;
    rst = r; start = s; stop = p; dir = d; limit = l;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got  = {count, t_vec, busy, done};
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got count=%h t_vec=%h busy=%b done=%b, want count=%h t_vec=%h busy=%b done=%b",
               name, got[9:6], got[5:2], got[1], got[0],
               want[9:6], want[5:2], want[1], want[0]);
    end
  endtask

  task automatic random_run(input int idx);
    logic       d;
    logic [3:0] l;
    logic [3:0] c;
    logic [3:0] prev;
    int         n;
    string      nm;
    d  = 1'($urandom_range(0, 1));
    l  = 4'($urandom_range(0, 15));
    c  = d ? 4'h0 : 4'hF;
    n  = d ? int'(l) : 15 - int'(l);
    nm = $sformatf("rand%0d_start", idx);
    drive_and_check(1'b1, 1'b1, 1'b0, d, l, {c, 4'h0, 1'b1, 1'b0}, nm);
    for (int i = 1; i <= n; i++) begin
      prev = c;
      c    = d ? c + 4'd1 : c - 4'd1;
      // scramble dir/limit mid-run; they must be ignored
      drive_and_check(1'b1, 1'($urandom_range(0, 1)), 1'b0,
                      1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      {c, prev ^ c, 1'b1, 1'b0},
                      $sformatf("rand%0d_step%0d", idx, i));
    end
    drive_and_check(1'b1, 1'b0, 1'b0, d, l, {c, 4'h0, 1'b0, 1'b1},
                    $sformatf("rand%0d_done", idx));
    drive_and_check(1'b1, 1'b0, 1'b0, d, l, {c, 4'h0, 1'b0, 1'b0},
                    $sformatf("rand%0d_idle", idx));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b1; limit = 4'h0;

    //                rst st sp d  lim    cnt   tv    b  dn
    // reset state
    vecs.push_back(mk(0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 4'h3, 4'h0, 4'h0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h0, 4'h0, 4'h0, 0, 0));
    // up run to 3
    vecs.push_back(mk(1, 1, 0, 1, 4'h3, 4'h0, 4'h0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h3, 4'h1, 4'h1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h3, 4'h2, 4'h3, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h3, 4'h3, 4'h1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h3, 4'h3, 4'h0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 4'h3, 4'h3, 4'h0, 0, 0));
    // down run F..C, then up run with limit 0 (zero toggles)
    vecs.push_back(mk(1, 1, 0, 0, 4'hC, 4'hF, 4'h0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4'hC, 4'hE, 4'h1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4'hC, 4'hD, 4'h3, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4'hC, 4'hC, 4'h1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4'hC, 4'hC, 4'h0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 4'hC, 4'hC, 4'h0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 4'h0, 4'h0, 4'h0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h0, 4'h0, 4'h0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 4'h0, 4'h0, 4'h0, 0, 0));
    // pause at 4 for 3 cycles, resume to 9
    vecs.push_back(mk(1, 1, 0, 1, 4'h9, 4'h0, 4'h0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h9, 4'h1, 4'h1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h9, 4'h2, 4'h3, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h9, 4'h3, 4'h1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h9, 4'h4, 4'h7, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 4'h9, 4'h4, 4'h0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h9, 4'h4, 4'h0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h9, 4'h4, 4'h0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 1, 4'h9, 4'h4, 4'h0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h9, 4'h5, 4'h1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h9, 4'h6, 4'h3, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h9, 4'h7, 4'h1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h9, 4'h8, 4'hF, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h9, 4'h9, 4'h1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h9, 4'h9, 4'h0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 4'h9, 4'h9, 4'h0, 0, 0));
    // start+stop priority: RUN->PAUSE, PAUSE->IDLE, IDLE no effect
    vecs.push_back(mk(1, 1, 0, 1, 4'h5, 4'h0, 4'h0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h5, 4'h1, 4'h1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h5, 4'h2, 4'h3, 1, 0));
    vecs.push_back(mk(1, 1, 1, 1, 4'h5, 4'h2, 4'h0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 1, 4'h5, 4'h2, 4'h0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h5, 4'h2, 4'h0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 4'h7, 4'h2, 4'h0, 0, 0));
    // reset mid-run at count 6
    vecs.push_back(mk(1, 1, 0, 1, 4'h9, 4'h0, 4'h0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h9, 4'h1, 4'h1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h9, 4'h2, 4'h3, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h9, 4'h3, 4'h1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h9, 4'h4, 4'h7, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h9, 4'h5, 4'h1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h9, 4'h6, 4'h3, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 4'h9, 4'h0, 4'h0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h9, 4'h0, 4'h0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h9, 4'h0, 4'h0, 0, 0));
    // reset during PAUSE wins over start
    vecs.push_back(mk(1, 1, 0, 1, 4'h9, 4'h0, 4'h0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h9, 4'h1, 4'h1, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 4'h9, 4'h1, 4'h0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 4'h9, 4'h0, 4'h0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h9, 4'h0, 4'h0, 0, 0));
    // latched dir/limit: change both mid-run, run still ends at 4
    vecs.push_back(mk(1, 1, 0, 1, 4'h4, 4'h0, 4'h0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4'h2, 4'h1, 4'h1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4'h2, 4'h2, 4'h3, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4'h2, 4'h3, 4'h1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4'h2, 4'h4, 4'h7, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4'h2, 4'h4, 4'h0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 4'h2, 4'h4, 4'h0, 0, 0));
    // down run with limit 15: immediate done, no toggles
    vecs.push_back(mk(1, 1, 0, 0, 4'hF, 4'hF, 4'h0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4'hF, 4'hF, 4'h0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 4'hF, 4'hF, 4'h0, 0, 0));

    // align input changes to just after a rising edge
    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive_and_check(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].dir,
                      vecs[i].limit,
                      {vecs[i].e_count, vecs[i].e_tvec, vecs[i].e_busy, vecs[i].e_done},
                      $sformatf("vec%0d", i));
    end

    for (int r = 0; r < 6; r++) begin
      random_run(r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tff_count_sequencer.md
TFF_COUNT_SEQUENCER -- requirements
Module: tff_count_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 start  input  1  level; begin a run from IDLE, or resume from PAUSE.
REQ-005 stop  input  1  level; pause from RUN, or abort from PAUSE.
REQ-006 dir  input  1  1 = count up, 0 = count down; latched on start from IDLE.
REQ-007 limit  input  4  terminal count; latched on start from IDLE.
REQ-008 count  output  4  registered state of the internal 4-bit T flip-flop bank.
REQ-009 t_vec  output  4  registered copy of the toggle vector applied at the most recent edge; 0 if nothing toggled.
REQ-010 busy  output  1  registered; 1 in RUN or PAUSE.
REQ-011 done  output  1  registered; 1-cycle pulse on completion.

Function
REQ-012 The state machine SHALL have four states: IDLE, RUN, PAUSE and DONE.
REQ-013 The count bank SHALL update only as count <= count XOR t, with t generated by the controller; no parallel load except start-from-IDLE and reset.
REQ-014 Up toggles: t[0]=1; t[i]=AND of count[i-1:0].
REQ-015 Down toggles: t[0]=1; t[i]=AND of ~count[i-1:0].
REQ-016 IDLE, start=1, stop=0: go to RUN; latch dir_r=dir and lim_r=limit; load count=4'h0 if dir=1, else 4'hF; t_vec=0.
REQ-017 IDLE, otherwise: hold count; t_vec=0.
REQ-018 RUN, stop=1: go to PAUSE; no toggle; t_vec=0.
REQ-019 RUN, stop=0, count==lim_r: go to DONE; no toggle; t_vec=0.
REQ-020 RUN, stop=0, count!=lim_r: apply the dir_r toggle vector; t_vec=that vector; stay in RUN.
REQ-021 RUN, start: ignored.
REQ-022 PAUSE, stop=1: go to IDLE (abort); count retained; no done pulse.
REQ-023 PAUSE, start=1, stop=0: go to RUN; no reload; dir_r and lim_r unchanged.
REQ-024 PAUSE, neither input: hold.
REQ-025 start and stop both high: stop SHALL win in every state; in IDLE, neither input has effect.
REQ-026 DONE SHALL last exactly one cycle with done=1, then go to IDLE; count holds the terminal value.
REQ-027 Changes to dir or limit after start from IDLE SHALL have no effect until the next start from IDLE.
REQ-028 Wrap-around: up 4'hF->4'h0 and down 4'h0->4'hF follow from the toggle rules; a run visits every value, so it terminates within 16 toggles.
REQ-029 Latency: start sampled at edge k gives the first toggle at edge k+1; with N = distance from the start value to lim_r, done is high for the cycle after edge k+N+1.
REQ-030 lim_r equal to the load value (up with limit=0, or down with limit=15): DONE is entered at edge k+1 with zero toggles.
REQ-031 busy and done SHALL never be high in the same cycle.

Reset
REQ-032 rst=0 at a rising edge SHALL force IDLE, count=0, t_vec=0, busy=0, done=0, dir_r=1 and lim_r=0, regardless of state.
REQ-033 Reset mid-RUN or mid-PAUSE SHALL abort with no done pulse; reset has priority over start and stop.

Verification
REQ-034 Up run: dir=1, limit=3, start pulse -> count 0,1,2,3 on successive edges; t_vec 1,3,1; done high 1 cycle with count=3; busy drops as done rises.
REQ-035 Down wrap: dir=0, limit=12, start -> count F,E,D,C; t_vec 1,3,1; then done; second run with dir=1, limit=0 -> count 0, immediate done, zero toggles.
REQ-036 Pause/resume: up run with limit=9, stop at count=4 for 3 cycles (count holds 4, t_vec=0, busy=1), then start -> continues 5..9; done once.
REQ-037 Abort and priority: in PAUSE, start=1 and stop=1 together -> IDLE, count retained, no done; in RUN, start=1 and stop=1 -> PAUSE.
REQ-038 Reset mid-run: rst=0 at count=6 -> next cycle count=0, busy=0, done=0, t_vec=0; no done pulse follows.
REQ-039 Latch check: change limit and dir during RUN -> run still ends at the value latched on start.
